dcache_direct_mapped: RTL

- Direct-mapped, write-back, write-allocate data cache between the EX/MEM pipeline stage and the 256-byte data memory.
- The CPU side takes word accesses on an 8-bit byte address.
- The memory side drives the data memory's block interface: 6-bit block address, 32-bit block, read/write strobes and busywait.
- Hits complete with zero stall. Misses stall the CPU via cpu_busywait while the FSM writes back and/or fetches a block.

---
 rtl/dcache_pkg.sv | 25 ++
 rtl/dcache_ctrl_fsm.sv | 95 +++++++++
 rtl/dcache_direct_mapped.sv | 116 +++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared widths, FSM state encoding and line layout for the direct-mapped data cache.
package dcache_pkg;

    localparam int DC_NUM_LINES = 8;
    localparam int DC_ADDR_W    = 8;
    localparam int DC_DATA_W    = 32;
    localparam int DC_IDX_W     = $clog2(DC_NUM_LINES);
    localparam int DC_TAG_W     = DC_ADDR_W - 2 - DC_IDX_W;
    localparam int DC_BLK_W     = DC_ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BACK,
        FETCH,
        UPDATE
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [DC_TAG_W-1:0]  tag;
        logic [DC_DATA_W-1:0] data;
    } line_t;

endpackage

// File: rtl/dcache_ctrl_fsm.sv
// Miss-handling controller: sequences write-back and fetch over the block memory
// interface and generates the CPU stall.
module dcache_ctrl_fsm
    import dcache_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 access_i,
    input  logic                 hit_i,
    input  logic                 victimDirty_i,
    input  logic [DC_BLK_W-1:0]  victimBlock_i,
    input  logic [DC_DATA_W-1:0] victimData_i,
    input  logic [DC_BLK_W-1:0]  cpuBlock_i,
    input  logic                 memBusywait_i,
    output state_t               state_o,
    output logic                 fetchDone_o,
    output logic                 cpuBusywait_o,
    output logic                 memRead_o,
    output logic                 memWrite_o,
    output logic [DC_BLK_W-1:0]  memAddress_o,
    output logic [DC_DATA_W-1:0] memWritedata_o
);

    state_t               state_q;
    logic                 firstCycle_q;
    logic                 memRead_q;
    logic                 memWrite_q;
    logic [DC_BLK_W-1:0]  memAddress_q;
    logic [DC_DATA_W-1:0] memWritedata_q;

    // The memory raises busywait combinationally from our strobe, so the entry
    // cycle of a memory state must never be taken as completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            firstCycle_q   <= 1'b0;
            memRead_q      <= 1'b0;
            memWrite_q     <= 1'b0;
            memAddress_q   <= '0;
            memWritedata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access_i && !hit_i) begin
                        firstCycle_q <= 1'b1;
                        if (victimDirty_i) begin
                            state_q        <= WRITE_BACK;
                            memWrite_q     <= 1'b1;
                            memAddress_q   <= victimBlock_i;
                            memWritedata_q <= victimData_i;
                        end else begin
                            state_q      <= FETCH;
                            memRead_q    <= 1'b1;
                            memAddress_q <= cpuBlock_i;
                        end
                    end
                end
                WRITE_BACK: begin
                    if (firstCycle_q) begin
                        firstCycle_q <= 1'b0;
                    end else if (!memBusywait_i) begin
                        state_q      <= FETCH;
                        firstCycle_q <= 1'b1;
                        memWrite_q   <= 1'b0;
                        memRead_q    <= 1'b1;
                        memAddress_q <= cpuBlock_i;
                    end
                end
                FETCH: begin
                    if (firstCycle_q) begin
                        firstCycle_q <= 1'b0;
                    end else if (!memBusywait_i) begin
                        state_q   <= UPDATE;
                        memRead_q <= 1'b0;
                    end
                end
                UPDATE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign state_o        = state_q;
    assign fetchDone_o    = (state_q == FETCH) && !firstCycle_q && !memBusywait_i;
    assign cpuBusywait_o  = (state_q == IDLE) ? (access_i && !hit_i) : 1'b1;
    assign memRead_o      = memRead_q;
    assign memWrite_o     = memWrite_q;
    assign memAddress_o   = memAddress_q;
    assign memWritedata_o = memWritedata_q;

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate data cache (one word per block).
// Defining DCACHE_STATS_EN adds saturating hit/miss counters.
module dcache_direct_mapped
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DC_NUM_LINES,
    parameter int ADDR_W    = DC_ADDR_W,
    parameter int DATA_W    = DC_DATA_W
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_misses
`endif
);

    line_t                lines_q [NUM_LINES];
    logic [DC_IDX_W-1:0]  index;
    logic [DC_TAG_W-1:0]  tag;
    logic                 access;
    logic                 hit;
    logic                 fetchDone;
    logic                 unusedAddrBits;
    state_t               state;

    assign index          = cpu_address[DC_IDX_W+1:2];
    assign tag            = cpu_address[ADDR_W-1:DC_IDX_W+2];
    assign unusedAddrBits = ^cpu_address[1:0];
    assign access         = cpu_read ^ cpu_write;
    assign hit            = lines_q[index].valid && (lines_q[index].tag == tag);
    assign cpu_readdata   = (state == IDLE) ? lines_q[index].data : '0;

    dcache_ctrl_fsm u_fsm (
        .clock          (clock),
        .reset          (reset),
        .access_i       (access),
        .hit_i          (hit),
        .victimDirty_i  (lines_q[index].valid && lines_q[index].dirty),
        .victimBlock_i  ({lines_q[index].tag, index}),
        .victimData_i   (lines_q[index].data),
        .cpuBlock_i     (cpu_address[ADDR_W-1:2]),
        .memBusywait_i  (mem_busywait),
        .state_o        (state),
        .fetchDone_o    (fetchDone),
        .cpuBusywait_o  (cpu_busywait),
        .memRead_o      (mem_read),
        .memWrite_o     (mem_write),
        .memAddress_o   (mem_address),
        .memWritedata_o (mem_writedata)
    );

    // A write miss is finished by the write-hit path once UPDATE has installed the tag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                lines_q[i] <= '0;
            end
        end else begin
            if (fetchDone) begin
                lines_q[index].data <= mem_readdata;
            end
            if (state == UPDATE) begin
                lines_q[index].tag   <= tag;
                lines_q[index].valid <= 1'b1;
                lines_q[index].dirty <= 1'b0;
            end
            if ((state == IDLE) && cpu_write && !cpu_read && hit) begin
                lines_q[index].data  <= cpu_writedata;
                lines_q[index].dirty <= 1'b1;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hits_q;
    logic [15:0] misses_q;
    logic        afterUpdate_q;

    // The hit that follows a refill belongs to an access already counted as a miss.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hits_q        <= '0;
            misses_q      <= '0;
            afterUpdate_q <= 1'b0;
        end else begin
            afterUpdate_q <= (state == UPDATE);
            if ((state == IDLE) && access) begin
                if (!hit) begin
                    if (misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
                end else if (!afterUpdate_q && (hits_q != 16'hFFFF)) begin
                    hits_q <= hits_q + 16'd1;
                end
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule
